// File: rtl/kernel_stream_src.sv
// ============================================================================
//  Module      : kernel_stream_src
//  Description : Paired y/vn arithmetic-sequence stream source with optional
//                LFSR-driven valid throttling and a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module kernel_stream_src #(
  parameter int          STREAMW   = 32,
  parameter int          CNTW      = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNTW-1:0]    nelem,
  input  logic [STREAMW-1:0] y_base,
  input  logic [STREAMW-1:0] y_step,
  input  logic [STREAMW-1:0] vn_base,
  input  logic [STREAMW-1:0] vn_step,
  input  logic               throttle_en,
  input  logic               iready,
  output logic               ovalid_y,
  output logic               ovalid_vn,
  output logic [STREAMW-1:0] y,
  output logic [STREAMW-1:0] vn,
  output logic               busy,
  output logic               done,
  output logic [CNTW-1:0]    sent_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state,    w_state_nxt;
  logic [CNTW-1:0]      r_nelem,    w_nelem_nxt;
  logic [STREAMW-1:0]   r_y_step,   w_y_step_nxt;
  logic [STREAMW-1:0]   r_vn_step,  w_vn_step_nxt;
  logic [STREAMW-1:0]   r_y,        w_y_nxt;
  logic [STREAMW-1:0]   r_vn,       w_vn_nxt;
  logic                 r_valid,    w_valid_nxt;
  logic [CNTW-1:0]      r_cnt,      w_cnt_nxt;
  logic [15:0]          r_lfsr;

  logic                 w_xfer;
  logic                 w_gate;
  logic [CNTW-1:0]      w_cnt_inc;
  logic                 w_lfsr_fb;

  assign w_xfer    = r_valid & iready;
  assign w_gate    = ~(throttle_en & r_lfsr[0]);
  assign w_cnt_inc = r_cnt + {{(CNTW-1){1'b0}}, 1'b1};
  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_comb begin
    w_state_nxt   = r_state;
    w_nelem_nxt   = r_nelem;
    w_y_step_nxt  = r_y_step;
    w_vn_step_nxt = r_vn_step;
    w_y_nxt       = r_y;
    w_vn_nxt      = r_vn;
    w_valid_nxt   = r_valid;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt_nxt = '0;
          if (nelem != '0) begin
            w_state_nxt   = S_RUN;
            w_nelem_nxt   = nelem;
            w_y_step_nxt  = y_step;
            w_vn_step_nxt = vn_step;
            w_y_nxt       = y_base;
            w_vn_nxt      = vn_base;
            w_valid_nxt   = w_gate;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (w_xfer) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == r_nelem) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_y_nxt     = r_y + r_y_step;
            w_vn_nxt    = r_vn + r_vn_step;
            w_valid_nxt = w_gate;
          end
        end else if (!r_valid) begin
          w_valid_nxt = w_gate;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_nelem   <= '0;
      r_y_step  <= '0;
      r_vn_step <= '0;
      r_y       <= '0;
      r_vn      <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      r_lfsr    <= LFSR_SEED;
    end else begin
      r_state   <= w_state_nxt;
      r_nelem   <= w_nelem_nxt;
      r_y_step  <= w_y_step_nxt;
      r_vn_step <= w_vn_step_nxt;
      r_y       <= w_y_nxt;
      r_vn      <= w_vn_nxt;
      r_valid   <= w_valid_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign ovalid_y  = r_valid;
  assign ovalid_vn = r_valid;
  assign y         = r_y;
  assign vn        = r_vn;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign sent_cnt  = r_cnt;

endmodule

`default_nettype wire
